// File: rtl/sal_timing_cfg.sv
// APB-programmable DRAM timing configuration: shadow registers written over APB,
// copied atomically into the active timing outputs once the scheduler has drained.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no apply pending, cfg_hold low
// S_HOLD   | apply requested, cfg_hold high, waiting for sched_idle
// S_COMMIT | one cycle: actives load from shadows, cfg_update pulses
module sal_timing_cfg #(
  parameter int          TW       = 5,
  parameter int          RFCW     = 10,
  parameter logic [31:0] DEF_ROW  = 32'h0F0A0A1A,
  parameter logic [31:0] DEF_REF  = 32'h0E07003F,
  parameter logic [31:0] DEF_BANK = 32'h07060303,
  parameter logic [31:0] DEF_DFI  = 32'h00100604
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [7:0]      paddr,
  input  logic [31:0]     pwdata,
  output logic [31:0]     prdata,
  output logic            pready,
  output logic            pslverr,
  input  logic            sched_idle,
  output logic            cfg_hold,
  output logic            cfg_update,
  output logic [TW-1:0]   t_rc_m1,
  output logic [TW-1:0]   t_rcd_m1,
  output logic [TW-1:0]   t_rp_m1,
  output logic [TW-1:0]   t_ras_m1,
  output logic [TW-1:0]   t_rtp_m1,
  output logic [TW-1:0]   t_wtp_m1,
  output logic [TW-1:0]   t_rrd_m1,
  output logic [TW-1:0]   t_ccd_m1,
  output logic [TW-1:0]   t_wtr_m1,
  output logic [TW-1:0]   t_rtw_m1,
  output logic [RFCW-1:0] t_rfc_m1,
  output logic [7:0]      row_open_cnt,
  output logic [3:0]      dfi_wren_lat,
  output logic [3:0]      dfi_rden_lat
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_ROW    = 8'h08;
  localparam logic [7:0] A_REF    = 8'h0C;
  localparam logic [7:0] A_BANK   = 8'h10;
  localparam logic [7:0] A_DFI    = 8'h14;

  typedef struct packed {
    logic [TW-1:0]   rc;
    logic [TW-1:0]   rcd;
    logic [TW-1:0]   rp;
    logic [TW-1:0]   ras;
    logic [RFCW-1:0] rfc;
    logic [TW-1:0]   rtp;
    logic [TW-1:0]   wtp;
    logic [TW-1:0]   rrd;
    logic [TW-1:0]   ccd;
    logic [TW-1:0]   wtr;
    logic [TW-1:0]   rtw;
    logic [3:0]      wren;
    logic [3:0]      rden;
    logic [7:0]      row_open;
  } timing_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_COMMIT
  } state_t;

  function automatic timing_t def_timing();
    timing_t t;
    t.rc       = DEF_ROW[0 +: TW];
    t.rcd      = DEF_ROW[8 +: TW];
    t.rp       = DEF_ROW[16 +: TW];
    t.ras      = DEF_ROW[24 +: TW];
    t.rfc      = DEF_REF[0 +: RFCW];
    t.rtp      = DEF_REF[16 +: TW];
    t.wtp      = DEF_REF[24 +: TW];
    t.rrd      = DEF_BANK[0 +: TW];
    t.ccd      = DEF_BANK[8 +: TW];
    t.wtr      = DEF_BANK[16 +: TW];
    t.rtw      = DEF_BANK[24 +: TW];
    t.wren     = DEF_DFI[3:0];
    t.rden     = DEF_DFI[11:8];
    t.row_open = DEF_DFI[23:16];
    return t;
  endfunction

  timing_t     shadow;
  timing_t     active;
  state_t      state;
  logic [7:0]  apply_cnt;
  logic        access;
  logic        addr_err;
  logic        wr_ok;
  logic        ctrl_wr;
  logic        pending;
  logic [31:0] rd_word;
  logic        unused_pwdata;

  assign access   = psel & penable;
  assign addr_err = (paddr >= 8'h18) || (paddr[1:0] != 2'b00);
  assign pslverr  = access & (addr_err | (pwrite & (paddr == A_STATUS)));
  assign pready   = 1'b1;
  assign wr_ok    = access & pwrite & ~pslverr;
  assign ctrl_wr  = wr_ok & (paddr == A_CTRL);
  assign pending  = (state != S_IDLE);

  // Field bits above each field width are simply dropped on write.
  assign unused_pwdata = ^pwdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= def_timing();
    end else if (wr_ok) begin
      case (paddr)
        A_ROW: begin
          shadow.rc  <= pwdata[0 +: TW];
          shadow.rcd <= pwdata[8 +: TW];
          shadow.rp  <= pwdata[16 +: TW];
          shadow.ras <= pwdata[24 +: TW];
        end
        A_REF: begin
          shadow.rfc <= pwdata[0 +: RFCW];
          shadow.rtp <= pwdata[16 +: TW];
          shadow.wtp <= pwdata[24 +: TW];
        end
        A_BANK: begin
          shadow.rrd <= pwdata[0 +: TW];
          shadow.ccd <= pwdata[8 +: TW];
          shadow.wtr <= pwdata[16 +: TW];
          shadow.rtw <= pwdata[24 +: TW];
        end
        A_DFI: begin
          shadow.wren     <= pwdata[3:0];
          shadow.rden     <= pwdata[11:8];
          shadow.row_open <= pwdata[23:16];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_word = '0;
    case (paddr)
      A_CTRL: rd_word[0] = pending;
      A_STATUS: begin
        rd_word[0]    = pending;
        rd_word[15:8] = apply_cnt;
      end
      A_ROW: begin
        rd_word[0 +: TW]  = shadow.rc;
        rd_word[8 +: TW]  = shadow.rcd;
        rd_word[16 +: TW] = shadow.rp;
        rd_word[24 +: TW] = shadow.ras;
      end
      A_REF: begin
        rd_word[0 +: RFCW] = shadow.rfc;
        rd_word[16 +: TW]  = shadow.rtp;
        rd_word[24 +: TW]  = shadow.wtp;
      end
      A_BANK: begin
        rd_word[0 +: TW]  = shadow.rrd;
        rd_word[8 +: TW]  = shadow.ccd;
        rd_word[16 +: TW] = shadow.wtr;
        rd_word[24 +: TW] = shadow.rtw;
      end
      A_DFI: begin
        rd_word[3:0]   = shadow.wren;
        rd_word[11:8]  = shadow.rden;
        rd_word[23:16] = shadow.row_open;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prdata <= '0;
    end else if (psel & ~penable) begin
      prdata <= rd_word;
    end
  end

  // ABORT takes priority over APPLY and over sched_idle in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_hold   <= 1'b0;
      cfg_update <= 1'b0;
      apply_cnt  <= '0;
      active     <= def_timing();
    end else begin
      cfg_update <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctrl_wr && pwdata[0] && !pwdata[1]) begin
            state    <= S_HOLD;
            cfg_hold <= 1'b1;
          end
        end
        S_HOLD: begin
          if (ctrl_wr && pwdata[1]) begin
            state    <= S_IDLE;
            cfg_hold <= 1'b0;
          end else if (sched_idle) begin
            state      <= S_COMMIT;
            cfg_update <= 1'b1;
          end
        end
        S_COMMIT: begin
          active    <= shadow;
          apply_cnt <= apply_cnt + 8'd1;
          cfg_hold  <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          cfg_hold <= 1'b0;
        end
      endcase
    end
  end

  assign t_rc_m1      = active.rc;
  assign t_rcd_m1     = active.rcd;
  assign t_rp_m1      = active.rp;
  assign t_ras_m1     = active.ras;
  assign t_rfc_m1     = active.rfc;
  assign t_rtp_m1     = active.rtp;
  assign t_wtp_m1     = active.wtp;
  assign t_rrd_m1     = active.rrd;
  assign t_ccd_m1     = active.ccd;
  assign t_wtr_m1     = active.wtr;
  assign t_rtw_m1     = active.rtw;
  assign dfi_wren_lat = active.wren;
  assign dfi_rden_lat = active.rden;
  assign row_open_cnt = active.row_open;

endmodule

// File: tb/tb_sal_timing_cfg.sv
// Bench for sal_timing_cfg: register table, hand sequences for apply/abort/commit
// corners, and a random APB mix checked against a word-level register model.
module tb_sal_timing_cfg;

  localparam int          TW       = 5;
  localparam int          RFCW     = 10;
  localparam logic [31:0] DEF_ROW  = 32'h0F0A0A1A;
  localparam logic [31:0] DEF_REF  = 32'h0E07003F;
  localparam logic [31:0] DEF_BANK = 32'h07060303;
  localparam logic [31:0] DEF_DFI  = 32'h00100604;

  logic            clk = 1'b0;
  logic            rst;
  logic            psel, penable, pwrite;
  logic [7:0]      paddr;
  logic [31:0]     pwdata;
  logic [31:0]     prdata;
  logic            pready, pslverr;
  logic            sched_idle;
  logic            cfg_hold, cfg_update;
  logic [TW-1:0]   t_rc_m1, t_rcd_m1, t_rp_m1, t_ras_m1, t_rtp_m1, t_wtp_m1;
  logic [TW-1:0]   t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
  logic [RFCW-1:0] t_rfc_m1;
  logic [7:0]      row_open_cnt;
  logic [3:0]      dfi_wren_lat, dfi_rden_lat;

  sal_timing_cfg #(
    .TW(TW), .RFCW(RFCW), .DEF_ROW(DEF_ROW), .DEF_REF(DEF_REF),
    .DEF_BANK(DEF_BANK), .DEF_DFI(DEF_DFI)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .sched_idle(sched_idle), .cfg_hold(cfg_hold),
    .cfg_update(cfg_update), .t_rc_m1(t_rc_m1), .t_rcd_m1(t_rcd_m1),
    .t_rp_m1(t_rp_m1), .t_ras_m1(t_ras_m1), .t_rtp_m1(t_rtp_m1),
    .t_wtp_m1(t_wtp_m1), .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1),
    .t_wtr_m1(t_wtr_m1), .t_rtw_m1(t_rtw_m1), .t_rfc_m1(t_rfc_m1),
    .row_open_cnt(row_open_cnt), .dfi_wren_lat(dfi_wren_lat),
    .dfi_rden_lat(dfi_rden_lat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: register words as software sees them (index = offset/4).
  logic [31:0] mdl_shadow [0:5];
  logic [31:0] mdl_active [0:5];
  int          mdl_cnt;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [0:19];

  function automatic logic [31:0] fmask(input int idx);
    logic [31:0] b;
    b = (32'd1 << TW) - 32'd1;
    case (idx)
      2, 4:    return b | (b << 8) | (b << 16) | (b << 24);
      3:       return ((32'd1 << RFCW) - 32'd1) | (b << 16) | (b << 24);
      5:       return 32'h00FF0F0F;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_err(input logic [7:0] a, input logic wr);
    return (a >= 8'h18) || (a[1:0] != 2'b00) || (wr && a == 8'h04);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a);
    if (a == 8'h00) return 32'h0;
    if (a == 8'h04) return 32'(mdl_cnt % 256) << 8;
    return mdl_shadow[a[4:2]];
  endfunction

  function automatic logic [31:0] dut_active(input int idx);
    case (idx)
      2: return (32'(t_ras_m1) << 24) | (32'(t_rp_m1) << 16) | (32'(t_rcd_m1) << 8) | 32'(t_rc_m1);
      3: return (32'(t_wtp_m1) << 24) | (32'(t_rtp_m1) << 16) | 32'(t_rfc_m1);
      4: return (32'(t_rtw_m1) << 24) | (32'(t_wtr_m1) << 16) | (32'(t_ccd_m1) << 8) | 32'(t_rrd_m1);
      5: return (32'(row_open_cnt) << 16) | (32'(dfi_rden_lat) << 8) | 32'(dfi_wren_lat);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [7:0] pick_addr(input int r);
    case (r)
      0: return 8'h04;
      1: return 8'h08;
      2: return 8'h0C;
      3: return 8'h10;
      4: return 8'h14;
      5: return 8'h18;
      6: return 8'h1C;
      7: return 8'h09;
      8: return 8'h0E;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_actives(input string name);
    for (int i = 2; i <= 5; i++)
      check_val($sformatf("%s_w%0d", name, i), dut_active(i), mdl_active[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge ending the access phase.
  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    @(negedge clk);
    err = pslverr;
    d = prdata;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_apply(input int k);
    logic [31:0] snap [0:5];
    logic        err, seen, bad;
    for (int i = 0; i <= 5; i++) snap[i] = mdl_shadow[i];
    sched_idle = 1'b0;
    apb_write(8'h00, 32'h1, err);
    bad = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (!cfg_hold || cfg_update) bad = 1'b1;
      tick();
    end
    sched_idle = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      if (cfg_update) seen = 1'b1;
      else if (!cfg_hold) bad = 1'b1;
      tick();
    end
    sched_idle = 1'b0;
    check_val("apply_hold_during_wait", 32'(bad), 32'h0);
    check_val("apply_update_seen", 32'(seen), 32'h1);
    for (int i = 0; i <= 5; i++) mdl_active[i] = snap[i];
    mdl_cnt = (mdl_cnt + 1) % 256;
    @(negedge clk);
    check_val("apply_after_hold_upd", {30'b0, cfg_hold, cfg_update}, 32'h0);
    check_actives("apply_actives");
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        err, bad;
    logic [31:0] rd, d;
    logic [7:0]  a;
    int          sel, n;
    logic [31:0] defs [0:5];

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; sched_idle = 1'b0;
    defs[0] = 32'h0; defs[1] = 32'h0; defs[2] = DEF_ROW;
    defs[3] = DEF_REF; defs[4] = DEF_BANK; defs[5] = DEF_DFI;
    for (int i = 0; i <= 5; i++) begin
      mdl_shadow[i] = defs[i] & fmask(i);
      mdl_active[i] = defs[i] & fmask(i);
    end
    mdl_cnt = 0;

    vt[0]  = '{1'b0, 8'h00, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[1]  = '{1'b0, 8'h04, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[2]  = '{1'b0, 8'h08, 32'h0,        1'b0, 1'b1, 32'h0F0A0A1A};
    vt[3]  = '{1'b0, 8'h0C, 32'h0,        1'b0, 1'b1, 32'h0E07003F};
    vt[4]  = '{1'b0, 8'h10, 32'h0,        1'b0, 1'b1, 32'h07060303};
    vt[5]  = '{1'b0, 8'h14, 32'h0,        1'b0, 1'b1, 32'h00100604};
    vt[6]  = '{1'b1, 8'h08, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 8'h08, 32'h0,        1'b0, 1'b1, 32'h1F1F1F1F};
    vt[8]  = '{1'b1, 8'h0C, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{1'b0, 8'h0C, 32'h0,        1'b0, 1'b1, 32'h1F1F03FF};
    vt[10] = '{1'b1, 8'h14, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
    vt[11] = '{1'b0, 8'h14, 32'h0,        1'b0, 1'b1, 32'h00FF0F0F};
    vt[12] = '{1'b0, 8'h18, 32'h0,        1'b1, 1'b0, 32'h0};
    vt[13] = '{1'b1, 8'h04, 32'h0000FF55, 1'b1, 1'b0, 32'h0};
    vt[14] = '{1'b0, 8'h04, 32'h0,        1'b0, 1'b1, 32'h0};
    vt[15] = '{1'b1, 8'h0A, 32'h12345678, 1'b1, 1'b0, 32'h0};
    vt[16] = '{1'b0, 8'h08, 32'h0,        1'b0, 1'b1, 32'h1F1F1F1F};
    vt[17] = '{1'b1, 8'h08, DEF_ROW,      1'b0, 1'b0, 32'h0};
    vt[18] = '{1'b1, 8'h0C, DEF_REF,      1'b0, 1'b0, 32'h0};
    vt[19] = '{1'b1, 8'h14, DEF_DFI,      1'b0, 1'b0, 32'h0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_val("rst_hold_upd", {30'b0, cfg_hold, cfg_update}, 32'h0);
    check_val("rst_prdata", prdata, 32'h0);
    check_val("rst_pslverr_pready", {30'b0, pslverr, pready}, 32'h1);
    check_val("rst_t_rc", 32'(t_rc_m1), 32'h1A);
    check_actives("rst_actives");
    tick();

    for (int i = 0; i < 20; i++) begin
      if (vt[i].wr) begin
        apb_write(vt[i].addr, vt[i].wdata, err);
        check_val($sformatf("tbl%0d_err", i), 32'(err), 32'(vt[i].exp_err));
      end else begin
        apb_read(vt[i].addr, rd, err);
        check_val($sformatf("tbl%0d_err", i), 32'(err), 32'(vt[i].exp_err));
        if (vt[i].chk_rd) check_val($sformatf("tbl%0d_rd", i), rd, vt[i].exp_rd);
      end
    end
    check_actives("tbl_actives_unchanged");

    // Apply with scheduler already idle: HOLD, COMMIT, then new values.
    apb_write(8'h10, 32'h04050606, err);
    mdl_shadow[4] = 32'h04050606 & fmask(4);
    sched_idle = 1'b1;
    apb_write(8'h00, 32'h1, err);
    @(negedge clk);
    check_val("apply_n1_hold_upd", {30'b0, cfg_hold, cfg_update}, 32'h2);
    tick();
    @(negedge clk);
    check_val("apply_n2_hold_upd", {30'b0, cfg_hold, cfg_update}, 32'h3);
    check_actives("apply_n2_old");
    tick();
    @(negedge clk);
    sched_idle = 1'b0;
    check_val("apply_n3_hold_upd", {30'b0, cfg_hold, cfg_update}, 32'h0);
    check_val("apply_bank", {t_rtw_m1, t_wtr_m1, t_ccd_m1, t_rrd_m1}, 32'({5'd4, 5'd5, 5'd6, 5'd6}));
    mdl_active[4] = mdl_shadow[4];
    mdl_cnt = 1;
    check_actives("apply_n3_new");
    tick();
    apb_read(8'h04, rd, err);
    check_val("status_after_apply", rd, 32'h100);

    // Long hold, then ABORT.
    apb_write(8'h08, 32'h0B0C0D0E, err);
    mdl_shadow[2] = 32'h0B0C0D0E & fmask(2);
    apb_write(8'h00, 32'h1, err);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cfg_hold || cfg_update) bad = 1'b1;
      for (int j = 2; j <= 5; j++) if (dut_active(j) !== mdl_active[j]) bad = 1'b1;
      tick();
    end
    check_val("hold20_stable", 32'(bad), 32'h0);
    apb_read(8'h00, rd, err);
    check_val("ctrl_pending", rd, 32'h1);
    apb_write(8'h00, 32'h2, err);
    @(negedge clk);
    check_val("abort_hold_drop", 32'(cfg_hold), 32'h0);
    tick();
    sched_idle = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (cfg_update || cfg_hold) bad = 1'b1;
      tick();
    end
    sched_idle = 1'b0;
    check_val("abort_no_update", 32'(bad), 32'h0);
    check_actives("abort_actives");
    apb_read(8'h04, rd, err);
    check_val("abort_status", rd, 32'h100);

    // Shadow write landing in the COMMIT cycle.
    sched_idle = 1'b1;
    apb_write(8'h00, 32'h1, err);
    apb_write(8'h08, 32'h01020304, err);
    @(negedge clk);
    sched_idle = 1'b0;
    mdl_active[2] = 32'h0B0C0D0E & fmask(2);
    mdl_shadow[2] = 32'h01020304 & fmask(2);
    mdl_cnt = 2;
    check_val("commitwr_hold", 32'(cfg_hold), 32'h0);
    check_val("commitwr_t_rc", 32'(t_rc_m1), 32'h0E);
    check_actives("commitwr_actives");
    tick();
    apb_read(8'h08, rd, err);
    check_val("commitwr_readback", rd, 32'h01020304);

    // APPLY|ABORT together in IDLE is a no-op.
    sched_idle = 1'b1;
    apb_write(8'h00, 32'h3, err);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cfg_update || cfg_hold) bad = 1'b1;
      tick();
    end
    sched_idle = 1'b0;
    check_val("apply_abort_noop", 32'(bad), 32'h0);

    // Error responses change nothing.
    apb_read(8'h18, rd, err);
    check_val("err_rd_0x18", 32'(err), 32'h1);
    apb_write(8'h04, 32'hFFFFFFFF, err);
    check_val("err_wr_status", 32'(err), 32'h1);
    apb_read(8'h04, rd, err);
    check_val("err_status_unchanged", rd, 32'h200);

    // Random APB mix against the model.
    for (int op = 0; op < 200; op++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: begin
          a = pick_addr(int'($urandom_range(0, 8)));
          d = $urandom;
          apb_write(a, d, err);
          check_val("rnd_wr_err", 32'(err), 32'(exp_err(a, 1'b1)));
          if (!exp_err(a, 1'b1) && a >= 8'h08) mdl_shadow[a[4:2]] = d & fmask(int'(a[4:2]));
        end
        1: begin
          a = pick_addr(int'($urandom_range(0, 9)));
          apb_read(a, rd, err);
          check_val("rnd_rd_err", 32'(err), 32'(exp_err(a, 1'b0)));
          if (!exp_err(a, 1'b0)) check_val("rnd_rd_data", rd, model_read(a));
        end
        2: do_apply(int'($urandom_range(0, 4)));
        default: begin
          tick();
          @(negedge clk);
          check_val("rnd_idle_hold", 32'(cfg_hold), 32'h0);
          check_actives("rnd_idle_actives");
          tick();
        end
      endcase
    end

    // Run the apply counter around to zero.
    n = 256 - (mdl_cnt % 256);
    for (int i = 0; i < n; i++) do_apply(0);
    apb_read(8'h04, rd, err);
    check_val("apply_cnt_wrap", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
